// File: rtl/register.sv
// rtl/register.sv - two-entry register file (R0, R1) with two read ports.
// Defining REGISTER_BYPASS_EN forwards the write data to the matching read port during the write cycle.
module register #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  input  logic             select_line,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  logic [WIDTH-1:0] r0_q;
  logic [WIDTH-1:0] r1_q;

  // Reset wins over a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r0_q <= RESET_VAL;
      r1_q <= RESET_VAL;
    end else if (write_en) begin
      if (select_line) r1_q <= data_in;
      else             r0_q <= data_in;
    end
  end

  assign R0 = r0_q;
  assign R1 = r1_q;

`ifdef REGISTER_BYPASS_EN
  // Write-through keeps the ALU operands current in the same cycle as the write.
  assign read_data1 = (reset && write_en && !select_line) ? data_in : r0_q;
  assign read_data2 = (reset && write_en &&  select_line) ? data_in : r1_q;
`else
  assign read_data1 = r0_q;
  assign read_data2 = r1_q;
`endif

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - scoreboard bench for register: directed plan, then random writes and resets.
module tb_register;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       write_en;
  logic       select_line;
  logic [3:0] R0, R1, read_data1, read_data2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] r0;
    logic [3:0] r1;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_r0, m_r1;

  register #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .write_en(write_en),
    .select_line(select_line), .R0(R0), .R1(R1),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the edge; the expected state for the next edge is queued here.
  task automatic drive(input logic rst, input logic we, input logic sel, input logic [3:0] din);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; write_en = we; select_line = sel; data_in = din;
    if (!rst) begin
      m_r0 = 4'b0000;
      m_r1 = 4'b0000;
    end else if (we) begin
      if (sel) m_r1 = din;
      else     m_r0 = din;
    end
    e.r0 = m_r0;
    e.r1 = m_r1;
    sb.push_back(e);
  endtask

  // Inputs still hold the captured values 1 unit after the edge, so bypassed read ports equal the flops.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("R0", R0, e.r0);
      check("R1", R1, e.r1);
      check("read_data1", read_data1, e.r0);
      check("read_data2", read_data2, e.r1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; write_en = 1'b0; select_line = 1'b0; data_in = 4'b0000;
    m_r0 = 4'b0000; m_r1 = 4'b0000;

    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 4'b1010);
    drive(1'b1, 1'b1, 1'b1, 4'b1100);
    drive(1'b1, 1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 4'b0001);
    drive(1'b1, 1'b1, 1'b0, 4'b0101);
    drive(1'b1, 1'b1, 1'b0, 4'b0110);
    drive(1'b0, 1'b1, 1'b1, 4'b0110);
    drive(1'b1, 1'b1, 1'b1, 4'b0011);
    #1;
`ifdef REGISTER_BYPASS_EN
    check("bypass_rd2", read_data2, 4'b0011);
`else
    check("pre_edge_rd2", read_data2, 4'b0000);
`endif
    check("pre_edge_rd1", read_data1, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 4'b1001);

    for (int i = 0; i < 40; i++) begin
      logic       rst;
      logic       we;
      logic       sel;
      logic [3:0] din;
      rst = ($urandom_range(0, 7) != 0);
      we  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      din = 4'($urandom_range(0, 15));
      drive(rst, we, sel, din);
    end

    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("sb_empty", 4'(sb.size()), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register.md
Name: register

Overview:
- Two-entry general-purpose register file (R0, R1) for the 4-bit CPU datapath.
- A single write port selects its target with a 1-bit select line.
- Both registers are always visible as direct outputs and on two read-data ports that feed the ALU operand inputs.
- One clock domain; synchronous active-low reset clears both entries.

Parameters:
- WIDTH, 4, data width of each register, of data_in and of all outputs.
- RESET_VAL, 0 (WIDTH bits), value loaded into R0 and R1 on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- data_in  input  WIDTH  write data.
- write_en  input  1  write enable, active-high.
- select_line  input  1  write target: 0 selects R0, 1 selects R1.
- R0  output  WIDTH  registered contents of entry 0.
- R1  output  WIDTH  registered contents of entry 1.
- read_data1  output  WIDTH  read port 1; always returns R0.
- read_data2  output  WIDTH  read port 2; always returns R1.

Interface rule (already decided): one clock; reset is synchronous and active-low (clk, reset).

Behaviour:
- State: two WIDTH-bit flops, R0 and R1. No other state.
- Reset:
  - On a rising clk with reset==0, R0 and R1 load RESET_VAL (0000).
  - Reset has priority over write_en.
  - There is no asynchronous path: outputs change only at a clock edge.
- Write: on a rising clk with reset==1 and write_en==1:
  - if select_line==0, R0 <= data_in;
  - if select_line==1, R1 <= data_in.
  - The non-selected register holds its value.
- Hold: with reset==1 and write_en==0, both registers hold regardless of data_in or select_line.
- Latency: a write is visible on R0/R1 and on read_data1/read_data2 immediately after the capturing edge (1 cycle).
- Read ports:
  - Combinational from the flops: read_data1 = R0, read_data2 = R1.
  - No read enable; no read latency beyond the flop output.
- Back-to-back writes to the same register on consecutive cycles: last write wins, one value per edge.
- Reset asserted mid-operation, including during a write cycle: the write is discarded and both registers are cleared at that edge. Normal writes resume on the first edge with reset==1.
- X/Z handling: an unknown select_line with write_en==1 is not a legal input; the bench must not drive it.
- Power-up: register contents are undefined until the first reset edge.

Optional Feature:
- Macro REGISTER_BYPASS_EN.
- When defined, the read ports forward write data combinationally in the write cycle:
  - read_data1 = data_in when write_en==1 && select_line==0 && reset==1, else R0.
  - read_data2 = data_in when write_en==1 && select_line==1 && reset==1, else R1.
  - R0 and R1 outputs are unaffected and remain pure flop outputs.
- When not defined, read_data1/read_data2 equal R0/R1 exactly, as specified above.

Test Plan:
1. Hold reset=0 for one edge with write_en=0, data_in=0000 -> R0=R1=read_data1=read_data2=0000.
2. Release reset, write_en=1, select_line=0, data_in=1010, one edge -> R0=1010, read_data1=1010, R1=0000.
3. select_line=1, data_in=1100, one edge -> R1=1100, read_data2=1100, R0 stays 1010.
4. select_line=0, data_in=1111, one edge -> R0=1111, R1 stays 1100 (overwrite, other entry untouched).
5. write_en=0, data_in=0001, select_line=1, several edges -> R0=1111 and R1=1100 unchanged.
6. Drive reset=0 for one edge with both registers loaded, including a cycle with write_en=1 and data_in=0110 -> both registers 0000 and the write is dropped. Then reset=1 with a write of 0011 to R1 -> R1=0011 next edge.
   - With REGISTER_BYPASS_EN defined, also check that read_data2 shows 0011 in the write cycle, before the edge.
